// File: rtl/glitch_cmd_master.sv
// Host-side initiator for the glitcher's 3-byte UART command protocol.
// Serializes one request, waits for the single response byte and classifies it.
module glitch_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned CNT_W          = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [7:0] i_cmd,
   input  logic [7:0] i_param,
   input  logic [7:0] i_data,
   output logic       tx_strobe,
   output logic [7:0] wr_byte,
   input  logic       tx_done,
   input  logic       rx_strobe,
   input  logic [7:0] rx_byte,
   output logic       o_rsp_valid,
   output logic [7:0] o_rsp_byte,
   output logic [1:0] o_rsp_status,
   output logic       o_busy,
   output logic       o_stray
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_DONE,
      S_WAIT_RSP,
      S_RESPOND
   } state_t;

   state_t           state, state_nx;
   logic [7:0]       cmd_q, param_q, data_q;
   logic [1:0]       idx_q, last_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept, timeout;
   logic [1:0]       cls_status;

   assign accept  = i_req_valid && (state == S_IDLE);
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (accept) state_nx = S_SEND;
         S_SEND:      state_nx = S_WAIT_DONE;
         S_WAIT_DONE: if (tx_done) state_nx = (idx_q == last_q) ? S_WAIT_RSP : S_SEND;
         S_WAIT_RSP:  if (rx_strobe || timeout) state_nx = S_RESPOND;
         S_RESPOND:   state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // READ/CHECKSTATE return data, so any byte is a valid payload for them.
   always_comb begin
      cls_status = 2'b11;
      case (cmd_q)
         8'h01, 8'h03, 8'h04, 8'h05: begin
            if (rx_byte == 8'hAA)      cls_status = 2'b00;
            else if (rx_byte == 8'hFF) cls_status = 2'b01;
            else                       cls_status = 2'b11;
         end
         8'h02, 8'h06: cls_status = 2'b00;
         default:      cls_status = (rx_byte == 8'hFF) ? 2'b01 : 2'b11;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cmd_q        <= '0;
         param_q      <= '0;
         data_q       <= '0;
         idx_q        <= '0;
         last_q       <= '0;
         cnt_q        <= '0;
         o_rsp_byte   <= '0;
         o_rsp_status <= '0;
         o_stray      <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cmd_q   <= i_cmd;
            param_q <= i_param;
            data_q  <= i_data;
            idx_q   <= '0;
            last_q  <= (i_cmd == 8'h02 || i_cmd == 8'h03) ? 2'd2 : 2'd0;
            o_stray <= 1'b0;
         end
         if (state == S_WAIT_DONE && tx_done && idx_q != last_q)
            idx_q <= idx_q + 2'd1;
         if (state == S_WAIT_RSP) cnt_q <= cnt_q + 1'b1;
         else                     cnt_q <= '0;
         if (state == S_WAIT_RSP) begin
            if (rx_strobe) begin
               o_rsp_byte   <= rx_byte;
               o_rsp_status <= cls_status;
            end else if (timeout) begin
               o_rsp_byte   <= '0;
               o_rsp_status <= 2'b10;
            end
         end
         // A stray byte on the accept cycle still counts, so set wins over clear.
         if (rx_strobe && state != S_WAIT_RSP) o_stray <= 1'b1;
      end
   end

   always_comb begin
      case (idx_q)
         2'd0:    wr_byte = cmd_q;
         2'd1:    wr_byte = param_q;
         default: wr_byte = data_q;
      endcase
   end

   assign o_req_ready = (state == S_IDLE);
   assign o_busy      = (state != S_IDLE);
   assign tx_strobe   = (state == S_SEND);
   assign o_rsp_valid = (state == S_RESPOND);

endmodule
